// File: rtl/hdc_pkg.sv
// Shared HDC definitions: default hypervector width, chunk-count helper and scheduler state type.
package hdc_pkg;

    localparam int unsigned HDC_DIMENSIONS = 10000;

    typedef enum logic {
        IDLE = 1'b0,
        BIND = 1'b1
    } bsched_state_t;

    function automatic int unsigned nchunk(input int unsigned d, input int unsigned c);
        return (d + c - 1) / c;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/binder_sched_binder.sv
// XOR binder of two DIMENSIONS-bit hypervectors; used by binder_sched as a CHUNK-wide slice.
module binder #(
    parameter int unsigned DIMENSIONS = 10000
) (
    input  logic [DIMENSIONS-1:0] hv_1_in,
    input  logic [DIMENSIONS-1:0] hv_2_in,
    output logic [DIMENSIONS-1:0] hv_out
);

    assign hv_out = hv_1_in ^ hv_2_in;

endmodule

// File: rtl/binder_sched.sv
// Round-robin scheduler sharing one CHUNK-wide binder slice across NUM_REQ requesters.
// Optional rho permutation of operand B is enabled with BINDER_SCHED_PERMUTE_EN.
module binder_sched
    import hdc_pkg::*;
#(
    parameter int unsigned DIMENSIONS = HDC_DIMENSIONS,
    parameter int unsigned CHUNK      = 1000,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DIMENSIONS-1:0]   hv_1_in,
    input  logic [NUM_REQ*DIMENSIONS-1:0]   hv_2_in,
`ifdef BINDER_SCHED_PERMUTE_EN
    input  logic [NUM_REQ-1:0]              perm,
`endif
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic [DIMENSIONS-1:0]           hv_out,
    output logic                            done,
    output logic [$clog2(NUM_REQ)-1:0]      done_id
);

    localparam int unsigned NCHUNK = nchunk(DIMENSIONS, CHUNK);
    localparam int unsigned IXW    = idx_width(NCHUNK);
    localparam int unsigned PW     = idx_width(DIMENSIONS);
    localparam int unsigned IDW    = $clog2(NUM_REQ);

    bsched_state_t          state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [IDW-1:0]         win_q, win_d;
    logic [IXW-1:0]         idx_q, idx_d;
    logic [DIMENSIONS-1:0]  op1_q, op1_d;
    logic [DIMENSIONS-1:0]  op2_q, op2_d;
    logic [DIMENSIONS-1:0]  hv_q, hv_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   done_q, done_d;
    logic [IDW-1:0]         done_id_q, done_id_d;

    logic [IDW-1:0]         pick;
    logic                   found;
    logic [DIMENSIONS-1:0]  cap_a, cap_b;
    logic [CHUNK-1:0]       slice_a, slice_b, slice_x;
    logic [DIMENSIONS-1:0]  hv_wr;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        cap_a = '0;
        cap_b = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (pick == IDW'(r)) begin
                cap_a = hv_1_in[r*DIMENSIONS +: DIMENSIONS];
                cap_b = hv_2_in[r*DIMENSIONS +: DIMENSIONS];
            end
        end
`ifdef BINDER_SCHED_PERMUTE_EN
        if (perm[pick]) begin
            cap_b = (cap_b << 1) | (cap_b >> (DIMENSIONS - 1));
        end
`endif
    end

    // Bit positions at or above DIMENSIONS (partial last chunk) read as 0 and are never written.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned b = 0; b < CHUNK; b++) begin
            int unsigned pos;
            pos = 32'(idx_q) * CHUNK + b;
            if (pos < DIMENSIONS) begin
                slice_a[b] = op1_q[pos[PW-1:0]];
                slice_b[b] = op2_q[pos[PW-1:0]];
            end
        end
    end

    binder #(
        .DIMENSIONS(CHUNK)
    ) u_slice (
        .hv_1_in(slice_a),
        .hv_2_in(slice_b),
        .hv_out (slice_x)
    );

    always_comb begin
        hv_wr = hv_q;
        for (int unsigned b = 0; b < CHUNK; b++) begin
            int unsigned pos;
            pos = 32'(idx_q) * CHUNK + b;
            if (pos < DIMENSIONS) begin
                hv_wr[pos[PW-1:0]] = slice_x[b];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        idx_d     = idx_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        hv_d      = hv_q;
        grant_d   = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    op1_d         = cap_a;
                    op2_d         = cap_b;
                    grant_d[pick] = 1'b1;
                    win_d         = pick;
                    idx_d         = '0;
                    ptr_d         = IDW'((32'(pick) + 1) % NUM_REQ);
                    state_d       = BIND;
                end
            end
            BIND: begin
                hv_d = hv_wr;
                if (idx_q == IXW'(NCHUNK - 1)) begin
                    idx_d     = '0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_id_d = win_q;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            idx_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            hv_q      <= '0;
            grant_q   <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            idx_q     <= idx_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            hv_q      <= hv_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q == BIND);
    assign hv_out  = hv_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_binder_sched.sv
// Self-checking bench for binder_sched: small (16/4/4), partial-chunk (16/5/4) and full-size instances.
module tb_binder_sched;

    localparam int D  = 16;
    localparam int NC = 4;
    localparam int BD = 10000;
    localparam int BN = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] h1  = '0;
    logic [63:0] h2  = '0;
`ifdef BINDER_SCHED_PERMUTE_EN
    logic [3:0]  perm   = '0;
    logic [3:0]  perm_b = '0;
`endif

    logic [3:0]  grant, grant5;
    logic        busy, busy5, done, done5;
    logic [15:0] hv_out, hv5;
    logic [1:0]  done_id, done_id5;

    logic [3:0]         req_b = '0;
    logic [4*BD-1:0]    h1_b  = '0;
    logic [4*BD-1:0]    h2_b  = '0;
    logic [3:0]         grant_b;
    logic               busy_b, done_b;
    logic [BD-1:0]      hv_b, expb, ea_b, eb_b;
    logic [1:0]         done_id_b;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int ptr_m  = 0;
    int ptrb_m = 0;

    always #5 clk = ~clk;

    binder_sched #(.DIMENSIONS(16), .CHUNK(4), .NUM_REQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .hv_1_in(h1), .hv_2_in(h2),
`ifdef BINDER_SCHED_PERMUTE_EN
        .perm(perm),
`endif
        .grant(grant), .busy(busy), .hv_out(hv_out), .done(done), .done_id(done_id)
    );

    binder_sched #(.DIMENSIONS(16), .CHUNK(5), .NUM_REQ(4)) dut5 (
        .clk(clk), .rst(rst), .req(req), .hv_1_in(h1), .hv_2_in(h2),
`ifdef BINDER_SCHED_PERMUTE_EN
        .perm(perm),
`endif
        .grant(grant5), .busy(busy5), .hv_out(hv5), .done(done5), .done_id(done_id5)
    );

    binder_sched #(.DIMENSIONS(10000), .CHUNK(1000), .NUM_REQ(4)) dut_big (
        .clk(clk), .rst(rst), .req(req_b), .hv_1_in(h1_b), .hv_2_in(h2_b),
`ifdef BINDER_SCHED_PERMUTE_EN
        .perm(perm_b),
`endif
        .grant(grant_b), .busy(busy_b), .hv_out(hv_b), .done(done_b), .done_id(done_id_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (r[j[1:0]]) return j;
        end
        return 0;
    endfunction

    task automatic do_bind(input logic [3:0] rq, input bit drop);
        int w, cnt;
        logic [15:0] ea, eb, ex;
        logic early;
        req = rq;
        w  = rr_pick(rq, ptr_m);
        ea = h1[w*16 +: 16];
        eb = h2[w*16 +: 16];
`ifdef BINDER_SCHED_PERMUTE_EN
        if (perm[w]) eb = {eb[14:0], eb[15]};
`endif
        ex  = ea ^ eb;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (grant === 4'b0 && cnt < 8);
        chk("grant", grant, 64'(4'b1 << w));
        chk("grant5", grant5, 64'(4'b1 << w));
        chk("grant_latency", cnt, 1);
        chk("busy_on", busy, 1);
        ptr_m = (w + 1) % 4;
        h1 = {$urandom(), $urandom()};
        h2 = {$urandom(), $urandom()};
        if (drop) req = '0;
        early = 1'b0;
        for (int c = 1; c <= NC; c++) begin
            tick();
            if (c == 1) chk("grant_pulse", grant, 0);
            if (c < NC) early = early | done | done5;
        end
        chk("early_done", early, 0);
        chk("done", done, 1);
        chk("hv_out", hv_out, ex);
        chk("done_id", done_id, w);
        chk("busy_off", busy, 0);
        chk("done5", done5, 1);
        chk("hv_out5", hv5, ex);
        chk("done_id5", done_id5, w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;
        int w, cnt;

        // Reset
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hv", hv_out, 16'h0000);
        chk("rst_done_id", done_id, 0);
        chk("rst_big_hv", 64'(|hv_b), 0);
        chk("rst_big_busy", busy_b, 0);
        rst = 1'b0;

        // Held all-request: rotation 0,1,2,3,0 with 5-cycle spacing
        for (int i = 0; i < 5; i++) begin
            h1 = {$urandom(), $urandom()};
            h2 = {$urandom(), $urandom()};
            do_bind(4'b1111, 1'b0);
        end

        h1[16 +: 16] = 16'hA5A5;
        h2[16 +: 16] = 16'h0FF0;
        do_bind(4'b0010, 1'b1);
        chk("t2_hv_const", hv_out, 16'hAA55);

        h1[0 +: 16] = 16'hFFFF;
        h2[0 +: 16] = 16'h1234;
        do_bind(4'b0001, 1'b1);
        chk("t4_partial_chunk", hv5, 16'hEDCB);

        // Reset during the second BIND cycle
        req = 4'b0100;
        tick();
        chk("t5_grant", grant, 4'b0100);
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_hv", hv_out, 0);
        chk("t5_hv5", hv5, 0);
        chk("t5_done", done, 0);
        early = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            early = early | done | done5 | busy;
        end
        chk("t5_no_done", early, 0);
        ptr_m  = 0;
        ptrb_m = 0;
        do_bind(4'b1010, 1'b1);
        do_bind(4'b1000, 1'b1);

`ifdef BINDER_SCHED_PERMUTE_EN
        perm = 4'b0001;
        h1[0 +: 16] = 16'h0000;
        h2[0 +: 16] = 16'h8001;
        do_bind(4'b0001, 1'b1);
        chk("t6_permute", hv_out, 16'h0003);
        perm = '0;
`endif

        for (int i = 0; i < 12; i++) begin
            h1 = {$urandom(), $urandom()};
            h2 = {$urandom(), $urandom()};
`ifdef BINDER_SCHED_PERMUTE_EN
            perm = 4'($urandom());
`endif
            do_bind(4'($urandom_range(1, 15)), 1'($urandom()));
        end
        req = '0;

        // Full-size instance
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < (4 * BD) / 32; i++) begin
                h1_b[i*32 +: 32] = $urandom();
                h2_b[i*32 +: 32] = $urandom();
            end
`ifdef BINDER_SCHED_PERMUTE_EN
            perm_b = 4'($urandom());
`endif
            req_b = 4'($urandom_range(1, 15));
            w = rr_pick(req_b, ptrb_m);
            ea_b = h1_b[w*BD +: BD];
            eb_b = h2_b[w*BD +: BD];
`ifdef BINDER_SCHED_PERMUTE_EN
            if (perm_b[w]) eb_b = {eb_b[BD-2:0], eb_b[BD-1]};
`endif
            expb = ea_b ^ eb_b;
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (grant_b === 4'b0 && cnt < 8);
            chk("big_grant", grant_b, 64'(4'b1 << w));
            chk("big_grant_latency", cnt, 1);
            ptrb_m = (w + 1) % 4;
            req_b = '0;
            for (int i = 0; i < (4 * BD) / 32; i++) h1_b[i*32 +: 32] = $urandom();
            early = 1'b0;
            for (int c = 1; c <= BN; c++) begin
                tick();
                if (c < BN) early = early | done_b;
            end
            chk("big_early_done", early, 0);
            chk("big_done", done_b, 1);
            chk("big_done_id", done_id_b, w);
            n_chk++;
            assert (hv_b === expb) n_pass++;
            else begin
                n_fail++;
                $error("FAIL big_hv: %0d bits differ from the required result", $countones(hv_b ^ expb));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
